uart_frame_echo: RTL and testbench
==================================

Name: uart_frame_echo

Overview:
- Parametrised UART receive-buffer-retransmit block: collects FRAME_BYTES bytes from rx into an internal buffer, then retransmits them in arrival order on tx.
- Successor to the fixed 4-byte/9600-baud echo path, adding:
  - configurable data width, parity and frame length
  - start-bit validation and mid-bit sampling
  - framing and parity error detection
  - inter-byte timeout flush of partial frames
  - sticky overrun reporting
- Sits between board UART pins and the monitoring header (rx_mon/tx_mon).

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD clocks per bit (integer truncation).
- DATA_BITS, 8, data bits per character, 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FRAME_BYTES, 4, characters per frame, 1..64.
- TIMEOUT_BITS, 40, idle bit-times after the last good character before a partial frame is flushed; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- rx  in  1  serial input, idle high, asynchronous to clk
- tx  out  1  serial output, idle high
- rx_mon  out  1  combinational copy of rx
- tx_mon  out  1  combinational copy of tx
- busy  out  1  high while the TX phase is active
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low
- parity_err  out  1  one-cycle pulse on parity mismatch
- overrun  out  1  sticky flag: a character completed while busy; cleared only by reset
- frame_cnt  out  16  number of frames transmitted, wraps at 65535 -> 0

Behaviour:
- Clocking and reset
  - Single clock domain; nrst asserted asynchronously clears all state.
  - Reset values: tx=1, busy=0, frame_err=0, parity_err=0, overrun=0, frame_cnt=0, buffer count=0.
- rx synchronisation: rx passes through a 2-flop synchroniser; all RX decisions use the synchronised value (2-cycle latency).
- RX FSM: R_IDLE -> R_START -> R_DATA -> R_PAR -> R_STOP.
  - R_IDLE: falling edge of synced rx loads the bit counter with DIV/2 and enters R_START.
  - R_START: at the half-bit sample, rx=1 is a glitch and returns to R_IDLE with no flags; rx=0 enters R_DATA.
  - R_DATA: samples every DIV clocks thereafter, LSB first, DATA_BITS samples.
  - R_PAR: entered only when PARITY != 0; one sample.
  - R_STOP: one sample.
    - Stop=0: frame_err pulse, character dropped; FSM waits in R_IDLE until synced rx=1 before re-arming.
    - Parity mismatch: parity_err pulses in the R_STOP sample cycle and the character is dropped.
    - Good character: written to the buffer in the same cycle; timeout counter cleared.
- Buffer
  - FRAME_BYTES x DATA_BITS register array with write index wr_idx.
  - wr_idx reaching FRAME_BYTES starts the TX phase on the next clock, with send count = FRAME_BYTES.
- Timeout
  - Counts bit-times while not busy and 0 < wr_idx < FRAME_BYTES.
  - Reaching TIMEOUT_BITS starts the TX phase with send count = wr_idx.
  - The counter is held at 0 when wr_idx = 0.
- TX FSM: T_IDLE -> T_START -> T_DATA -> T_PAR -> T_STOP -> T_GAP.
  - Each state lasts exactly DIV clocks.
  - T_START drives 0, T_DATA drives bits LSB first, T_PAR drives the parity bit (skipped if PARITY=0), T_STOP drives 1.
  - T_GAP drives 1 for one extra bit-time between characters.
  - busy rises in the cycle the TX phase starts; tx falls to the start bit in the same cycle.
  - After the last character's T_GAP: busy=0, wr_idx=0, frame_cnt increments.
- Characters completing while busy=1 are not stored and set overrun. RX keeps decoding so line sync is not lost.
- Simultaneous events:
  - Timeout expiry in the same cycle as a good character write: the write wins, then normal full/timeout evaluation applies the next cycle.
  - A full-buffer start takes precedence over timeout.
- Counter widths: bit and timeout counters are clog2-sized from DIV and TIMEOUT_BITS; no overflow is permitted by construction.

Decomposition:
- uart_pkg holds:
  - parity enum (PAR_NONE/PAR_EVEN/PAR_ODD)
  - RX and TX state enums
  - function clog2
  - function parity_of(data, mode)
- One sub-module, uart_rx_core: synchroniser, RX FSM and sampling, error pulses.
  - Outputs: rx_valid, rx_data[DATA_BITS-1:0], frame_err, parity_err.
  - Buffer, timeout and TX logic stay in the top.

Test Plan:
- Defaults (DIV=1250): send 0x53, 0x6E, 0x61, 0x70 -> busy rises after the 4th stop sample; tx reproduces the 4 characters LSB first, start-to-start spacing 11 bit-times (13750 clks); frame_cnt=1.
- 600-clk low glitch on idle rx -> no flags, nothing buffered, tx stays 1.
- Send 0xA5 with stop bit forced 0 -> frame_err pulses once; following 4 good characters echo correctly.
- PARITY=1: send 0x01 with parity bit 0 -> parity_err pulse, character dropped; send 0x03 with parity 0 -> accepted.
- Send 2 characters, then idle 40 bit-times -> TX phase sends exactly those 2; wr_idx returns to 0.
- Send 0x11 during an active TX phase -> overrun=1 and remains set; echoed data unchanged. Assert nrst mid-character -> tx=1 and busy=0 immediately, overrun cleared.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame echo path.
// State encodings are plain constants so older blocks can reuse them.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef logic [2:0] rx_state_t;
  typedef logic [2:0] tx_state_t;

  localparam rx_state_t R_IDLE  = 3'd0;
  localparam rx_state_t R_START = 3'd1;
  localparam rx_state_t R_DATA  = 3'd2;
  localparam rx_state_t R_PAR   = 3'd3;
  localparam rx_state_t R_STOP  = 3'd4;

  localparam tx_state_t T_IDLE  = 3'd0;
  localparam tx_state_t T_START = 3'd1;
  localparam tx_state_t T_DATA  = 3'd2;
  localparam tx_state_t T_PAR   = 3'd3;
  localparam tx_state_t T_STOP  = 3'd4;
  localparam tx_state_t T_GAP   = 3'd5;

  // Bits needed to hold 0..value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value - 1;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  // Zero padding above the character width leaves the XOR unchanged.
  function automatic logic parity_of(input logic [8:0] data, input parity_t mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and
// single-cycle valid / framing / parity pulses at the stop sample.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = clog2(DIV);
  localparam int BW  = clog2(DATA_BITS);
  localparam parity_t PMODE = parity_t'(2'(PARITY));
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_sample, par_ok;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign stop_sample = (state == R_STOP) && (cnt == '0);
  assign par_ok      = (PMODE == PAR_NONE) || (par_bit == parity_of(9'(shreg), PMODE));
  assign rx_valid    = stop_sample && rx_sync && par_ok;
  assign frame_err   = stop_sample && !rx_sync;
  assign parity_err  = stop_sample && rx_sync && !par_ok;
  assign rx_data     = shreg;

  // Idle re-arms only on a 1->0 edge, so a held-low break after a framing
  // error cannot start a new character until the line has returned high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (state != R_IDLE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      case (state)
        R_IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF;
            state <= R_START;
          end
        end
        R_START: begin
          cnt     <= FULL;
          bit_idx <= '0;
          state   <= rx_sync ? R_IDLE : R_DATA;
        end
        R_DATA: begin
          cnt     <= FULL;
          shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == LAST) state <= (PMODE == PAR_NONE) ? R_STOP : R_PAR;
        end
        R_PAR: begin
          cnt     <= FULL;
          par_bit <= rx_sync;
          state   <= R_STOP;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_echo.sv
// Collects FRAME_BYTES characters (or a timed-out partial frame) from rx
// and retransmits them in arrival order on tx.
module uart_frame_echo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 9600,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FRAME_BYTES  = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        rx,
  output logic        tx,
  output logic        rx_mon,
  output logic        tx_mon,
  output logic        busy,
  output logic        frame_err,
  output logic        parity_err,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = clog2(DIV);
  localparam int AW  = clog2(FRAME_BYTES);
  localparam int IW  = clog2(FRAME_BYTES + 1);
  localparam int TW  = clog2(TIMEOUT_BITS + 1);
  localparam int BW  = clog2(DATA_BITS);
  localparam parity_t PMODE = parity_t'(2'(PARITY));
  localparam logic [CW-1:0] FULL     = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST     = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] FB       = IW'(FRAME_BYTES);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_BITS);
  localparam logic [AW-1:0] FIRST    = '0;

  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] buf_mem [2**AW];
  logic [IW-1:0]        wr_idx, send_cnt;
  logic [AW-1:0]        rd_idx;
  logic [CW-1:0]        to_div, tcnt;
  logic [TW-1:0]        to_cnt;
  tx_state_t            tstate;
  logic [BW-1:0]        tbit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 to_active, start_full, start_to, tx_start, last_char, tx_done;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DATA_BITS(DATA_BITS),
    .PARITY   (PARITY)
  ) u_rx (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  assign rx_mon = rx;
  assign tx_mon = tx;

  // A character written this cycle beats a timeout expiring in the same cycle.
  assign to_active  = !busy && (wr_idx != '0) && (wr_idx < FB);
  assign start_full = !busy && (wr_idx == FB);
  assign start_to   = (TIMEOUT_BITS != 0) && to_active && (to_cnt == TO_LIMIT) && !rx_valid;
  assign tx_start   = start_full || start_to;
  assign last_char  = (IW'(rd_idx) + IW'(1)) == send_cnt;
  assign tx_done    = (tstate == T_GAP) && (tcnt == '0) && last_char;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buf_mem <= '{default: '0};
      wr_idx  <= '0;
      overrun <= 1'b0;
      to_div  <= '0;
      to_cnt  <= '0;
    end else begin
      if (rx_valid && (busy || wr_idx >= FB)) overrun <= 1'b1;
      if (rx_valid && !busy && wr_idx < FB) begin
        buf_mem[wr_idx[AW-1:0]] <= rx_data;
        wr_idx <= wr_idx + 1'b1;
      end else if (tx_done) begin
        wr_idx <= '0;
      end
      if (!to_active || rx_valid || tx_start) begin
        to_div <= '0;
        to_cnt <= '0;
      end else if (to_cnt != TO_LIMIT) begin
        if (to_div == FULL) begin
          to_div <= '0;
          to_cnt <= to_cnt + 1'b1;
        end else begin
          to_div <= to_div + 1'b1;
        end
      end
    end
  end

  // Every TX state lasts DIV clocks; the gap state adds one idle bit-time
  // between characters before the next start bit or the end of the frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tstate    <= T_IDLE;
      tcnt      <= '0;
      tbit      <= '0;
      rd_idx    <= '0;
      send_cnt  <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else if (tx_start) begin
      busy     <= 1'b1;
      tstate   <= T_START;
      tcnt     <= FULL;
      tx       <= 1'b0;
      rd_idx   <= '0;
      send_cnt <= start_full ? FB : wr_idx;
      tx_shift <= buf_mem[FIRST];
      tx_par   <= parity_of(9'(buf_mem[FIRST]), PMODE);
    end else if (tstate != T_IDLE) begin
      if (tcnt != '0) begin
        tcnt <= tcnt - 1'b1;
      end else begin
        tcnt <= FULL;
        case (tstate)
          T_START: begin
            tstate <= T_DATA;
            tbit   <= '0;
            tx     <= tx_shift[0];
          end
          T_DATA: begin
            if (tbit == LAST) begin
              tstate <= (PMODE == PAR_NONE) ? T_STOP : T_PAR;
              tx     <= (PMODE == PAR_NONE) ? 1'b1 : tx_par;
            end else begin
              tbit     <= tbit + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
          T_PAR: begin
            tstate <= T_STOP;
            tx     <= 1'b1;
          end
          T_STOP: begin
            tstate <= T_GAP;
            tx     <= 1'b1;
          end
          T_GAP: begin
            if (last_char) begin
              tstate    <= T_IDLE;
              busy      <= 1'b0;
              frame_cnt <= frame_cnt + 1'b1;
            end else begin
              tstate   <= T_START;
              tx       <= 1'b0;
              rd_idx   <= rd_idx + 1'b1;
              tx_shift <= buf_mem[rd_idx + 1'b1];
              tx_par   <= parity_of(9'(buf_mem[rd_idx + 1'b1]), PMODE);
            end
          end
          default: tstate <= T_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_echo.sv
// Directed bench for uart_frame_echo: a no-parity instance and an even-parity
// instance run at DIV=16 so whole frames fit in a short simulation.
module tb_uart_frame_echo;

  localparam int CLK_FREQ = 160000;
  localparam int BAUD     = 10000;
  localparam int DIV      = 16;
  localparam int BIT_T    = DIV * 10;

  logic        clk = 1'b0;
  logic        nrst;
  logic        rx0, rx1;
  logic        tx0, rx_mon0, tx_mon0, busy0, frame_err0, parity_err0, overrun0;
  logic        tx1, rx_mon1, tx_mon1, busy1, frame_err1, parity_err1, overrun1;
  logic [15:0] frame_cnt0, frame_cnt1;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int fe0 = 0, pe0 = 0, fe1 = 0, pe1 = 0;

  logic [7:0] q0_data [$];
  longint     q0_time [$];
  logic [7:0] q1_data [$];
  logic       q1_par  [$];

  logic [7:0] pat_a [4] = '{8'h53, 8'h6E, 8'h61, 8'h70};
  logic [7:0] pat_b [4] = '{8'h12, 8'h34, 8'hC8, 8'h0F};
  logic [7:0] pat_c [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  always #5 clk = ~clk;

  uart_frame_echo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
    .FRAME_BYTES(4), .TIMEOUT_BITS(40)
  ) dut (
    .clk(clk), .nrst(nrst), .rx(rx0), .tx(tx0), .rx_mon(rx_mon0), .tx_mon(tx_mon0),
    .busy(busy0), .frame_err(frame_err0), .parity_err(parity_err0),
    .overrun(overrun0), .frame_cnt(frame_cnt0)
  );

  uart_frame_echo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
    .FRAME_BYTES(4), .TIMEOUT_BITS(40)
  ) dut_par (
    .clk(clk), .nrst(nrst), .rx(rx1), .tx(tx1), .rx_mon(rx_mon1), .tx_mon(tx_mon1),
    .busy(busy1), .frame_err(frame_err1), .parity_err(parity_err1),
    .overrun(overrun1), .frame_cnt(frame_cnt1)
  );

  // Error pulses last a whole cycle, so the falling clock edge catches each once.
  always @(negedge clk) begin
    if (frame_err0 === 1'b1) fe0++;
    if (parity_err0 === 1'b1) pe0++;
    if (frame_err1 === 1'b1) fe1++;
    if (parity_err1 === 1'b1) pe1++;
  end

  initial begin : mon_tx0
    logic [7:0] d;
    longint     t0;
    forever begin
      @(negedge tx0);
      t0 = $time;
      #(BIT_T / 2 + 5);
      if (tx0 == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_T);
          d[i] = tx0;
        end
        q0_data.push_back(d);
        q0_time.push_back(t0);
      end
    end
  end

  initial begin : mon_tx1
    logic [7:0] d;
    logic       p;
    forever begin
      @(negedge tx1);
      #(BIT_T / 2 + 5);
      if (tx1 == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT_T);
          d[i] = tx1;
        end
        #(BIT_T);
        p = tx1;
        q1_data.push_back(d);
        q1_par.push_back(p);
      end
    end
  end

  function automatic logic [7:0] q0_at(input int i);
    return (i < q0_data.size()) ? q0_data[i] : 8'hxx;
  endfunction

  function automatic longint q0_t(input int i);
    return (i < q0_time.size()) ? q0_time[i] : 64'd0;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive_rx(input int lane, input logic v);
    if (lane == 0) rx0 = v;
    else rx1 = v;
  endtask

  // One character: start, 8 data bits LSB first, optional parity, stop.
  task automatic apply_stimulus(input int lane, input logic [7:0] data, input logic has_par,
                                input logic par, input logic stop);
    drive_rx(lane, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(lane, data[i]);
      repeat (DIV) @(negedge clk);
    end
    if (has_par) begin
      drive_rx(lane, par);
      repeat (DIV) @(negedge clk);
    end
    drive_rx(lane, stop);
    repeat (DIV) @(negedge clk);
    drive_rx(lane, 1'b1);
  endtask

  task automatic wait_frames(input int lane, input logic [15:0] target, input int budget,
                             input string tag);
    int n;
    n = 0;
    while (((lane == 0) ? frame_cnt0 : frame_cnt1) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, (lane == 0) ? frame_cnt0 : frame_cnt1, target);
  endtask

  initial begin : stim
    int n;
    nrst = 1'b0;
    rx0  = 1'b1;
    rx1  = 1'b1;
    repeat (4) @(negedge clk);
    check_output("reset_tx", tx0, 1'b1);
    check_output("reset_busy", busy0, 1'b0);
    check_output("reset_frame_err", frame_err0, 1'b0);
    check_output("reset_parity_err", parity_err0, 1'b0);
    check_output("reset_overrun", overrun0, 1'b0);
    check_output("reset_frame_cnt", frame_cnt0, 16'd0);
    check_output("reset_tx_mon", tx_mon0, 1'b1);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] full frame echo");
    for (int i = 0; i < 4; i++) apply_stimulus(0, pat_a[i], 1'b0, 1'b0, 1'b1);
    check_output("t1_busy_after_4th", busy0, 1'b1);
    wait_frames(0, 16'd1, 1000, "t1_frame_cnt");
    check_output("t1_echo_count", q0_data.size(), 4);
    for (int i = 0; i < 4; i++) check_output($sformatf("t1_echo_%0d", i), q0_at(i), pat_a[i]);
    check_output("t1_spacing_01", 32'(q0_t(1) - q0_t(0)), 11 * BIT_T);
    check_output("t1_spacing_23", 32'(q0_t(3) - q0_t(2)), 11 * BIT_T);
    check_output("t1_busy_done", busy0, 1'b0);
    check_output("t1_no_frame_err", fe0, 0);

    $display("[TB] start-bit glitch");
    rx0 = 1'b0;
    @(negedge clk);
    check_output("t2_rx_mon_low", rx_mon0, 1'b0);
    repeat (5) @(negedge clk);
    rx0 = 1'b1;
    repeat (45 * DIV) @(negedge clk);
    check_output("t2_no_frame_err", fe0, 0);
    check_output("t2_tx_idle", tx0, 1'b1);
    check_output("t2_nothing_echoed", q0_data.size(), 4);
    check_output("t2_frame_cnt", frame_cnt0, 16'd1);

    $display("[TB] framing error then good frame");
    apply_stimulus(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    check_output("t3_frame_err_once", fe0, 1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, pat_b[i], 1'b0, 1'b0, 1'b1);
    wait_frames(0, 16'd2, 1000, "t3_frame_cnt");
    check_output("t3_echo_count", q0_data.size(), 8);
    for (int i = 0; i < 4; i++) check_output($sformatf("t3_echo_%0d", i), q0_at(4 + i), pat_b[i]);
    check_output("t3_no_parity_err", pe0, 0);

    $display("[TB] even parity instance");
    apply_stimulus(1, 8'h01, 1'b1, 1'b0, 1'b1);
    check_output("t4_parity_err", pe1, 1);
    apply_stimulus(1, 8'h03, 1'b1, 1'b0, 1'b1);
    check_output("t4_good_no_parity_err", pe1, 1);
    check_output("t4_no_frame_err", fe1, 0);
    wait_frames(1, 16'd1, 1500, "t4_frame_cnt");
    check_output("t4_echo_count", q1_data.size(), 1);
    check_output("t4_echo_data", (q1_data.size() > 0) ? q1_data[0] : 8'hxx, 8'h03);
    check_output("t4_echo_parity", (q1_par.size() > 0) ? q1_par[0] : 1'bx, 1'b0);

    $display("[TB] partial frame timeout");
    apply_stimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (30 * DIV) @(negedge clk);
    check_output("t5_no_early_flush", busy0, 1'b0);
    wait_frames(0, 16'd3, 1500, "t5_frame_cnt");
    check_output("t5_echo_count", q0_data.size(), 10);
    check_output("t5_echo_0", q0_at(8), 8'h5A);
    check_output("t5_echo_1", q0_at(9), 8'hC3);

    $display("[TB] overrun and reset");
    for (int i = 0; i < 4; i++) apply_stimulus(0, pat_c[i], 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check_output("t6_overrun_set", overrun0, 1'b1);
    wait_frames(0, 16'd4, 1000, "t6_frame_cnt");
    check_output("t6_echo_count", q0_data.size(), 14);
    for (int i = 0; i < 4; i++) check_output($sformatf("t6_echo_%0d", i), q0_at(10 + i), pat_c[i]);
    check_output("t6_overrun_sticky", overrun0, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, pat_b[i], 1'b0, 1'b0, 1'b1);
    n = 0;
    while (tx0 !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("t6_tx_start_bit", tx0, 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check_output("t6_reset_tx", tx0, 1'b1);
    check_output("t6_reset_busy", busy0, 1'b0);
    check_output("t6_reset_overrun", overrun0, 1'b0);
    check_output("t6_reset_frame_cnt", frame_cnt0, 16'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    check_output("t6_post_reset_tx", tx0, 1'b1);
    check_output("t6_post_reset_busy", busy0, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
